// File: rtl/bus_arbiter_mux_if.sv
// Purpose: bundle of the two-master request side and the slave-facing routed bus of the arbiter.
// Latency: none (wires only).
// Backpressure: none; masters hold req until their grant arrives.
//
// Signals:
//   m0_*/m1_*  master request, write strobe, address, write data
//   s*_dout    registered read data from the four slaves
//   m*_grant   bus ownership, s_addr/s_wr/s_din routed bus, s*_sel slave selects
//   m_din      read data returned to both masters
// Modports:
//   master  arbiter side (it drives the shared slave bus)
//   slave   environment side (masters and slaves attached to the arbiter)
interface bus_arbiter_mux_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
);
  logic              m0_req;
  logic              m0_wr;
  logic [ADDR_W-1:0] m0_addr;
  logic [DATA_W-1:0] m0_dout;
  logic              m1_req;
  logic              m1_wr;
  logic [ADDR_W-1:0] m1_addr;
  logic [DATA_W-1:0] m1_dout;
  logic [DATA_W-1:0] s0_dout;
  logic [DATA_W-1:0] s1_dout;
  logic [DATA_W-1:0] s2_dout;
  logic [DATA_W-1:0] s3_dout;
  logic              m0_grant;
  logic              m1_grant;
  logic [ADDR_W-1:0] s_addr;
  logic              s_wr;
  logic [DATA_W-1:0] s_din;
  logic              s0_sel;
  logic              s1_sel;
  logic              s2_sel;
  logic              s3_sel;
  logic [DATA_W-1:0] m_din;

  modport master (
    input  m0_req, m0_wr, m0_addr, m0_dout,
    input  m1_req, m1_wr, m1_addr, m1_dout,
    input  s0_dout, s1_dout, s2_dout, s3_dout,
    output m0_grant, m1_grant, s_addr, s_wr, s_din,
    output s0_sel, s1_sel, s2_sel, s3_sel, m_din
  );

  modport slave (
    output m0_req, m0_wr, m0_addr, m0_dout,
    output m1_req, m1_wr, m1_addr, m1_dout,
    output s0_dout, s1_dout, s2_dout, s3_dout,
    input  m0_grant, m1_grant, s_addr, s_wr, s_din,
    input  s0_sel, s1_sel, s2_sel, s3_sel, m_din
  );
endinterface

// File: rtl/bus_arbiter_mux.sv
// Purpose: two-master non-preemptive bus arbiter with address/data routing and slave decode.
// Latency: grant changes one edge after the request change; read data returns one cycle after address.
// Backpressure: a waiting master simply holds req; the owner keeps the bus until it drops req.
//
// Ports:
//   clk, reset  rising-edge clock, synchronous active-high reset
//   bus         bus_arbiter_mux_if.master: master requests in, routed slave bus,
//               one-hot slave selects, grants and returned read data out
module bus_arbiter_mux #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  bus_arbiter_mux_if.master       bus
);

  typedef enum logic {M0_GNT = 1'b0, M1_GNT = 1'b1} state_t;

  state_t            state_q;
  state_t            state_d;
  logic [3:0]        rsel_q;
  logic [3:0]        sel;
  logic [ADDR_W-1:0] addr_mux;
  logic [DATA_W-1:0] din_mux;
  logic              wr_mux;
  logic              m0_grant_c;
  logic              m1_grant_c;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= M0_GNT;
      rsel_q  <= 4'b0000;
    end else begin
      state_q <= state_d;
      // remember which slave was addressed so its registered data can be steered back
      rsel_q  <= sel;
    end
  end

  // Next state plus grant/routing outputs, all decoded from the current owner.
  always_comb begin
    state_d    = state_q;
    m0_grant_c = 1'b1;
    m1_grant_c = 1'b0;
    addr_mux   = bus.m0_addr;
    din_mux    = bus.m0_dout;
    wr_mux     = bus.m0_wr & bus.m0_req;
    case (state_q)
      M0_GNT: begin
        // M0 keeps the bus on simultaneous requests
        if (!bus.m0_req && bus.m1_req) state_d = M1_GNT;
      end
      M1_GNT: begin
        m0_grant_c = 1'b0;
        m1_grant_c = 1'b1;
        addr_mux   = bus.m1_addr;
        din_mux    = bus.m1_dout;
        wr_mux     = bus.m1_wr & bus.m1_req;
        // non-preemptive: only M1 releasing its request returns the bus
        if (!bus.m1_req) state_d = M0_GNT;
      end
      default: state_d = M0_GNT;
    endcase
  end

  // Slave decode on the top nibble; 0x6..0xF selects nothing, so writes there are dropped.
  always_comb begin
    sel = 4'b0000;
    case (addr_mux[7:4])
      4'h0:       sel = 4'b0001;
      4'h1:       sel = 4'b0010;
      4'h2, 4'h3: sel = 4'b0100;
      4'h4, 4'h5: sel = 4'b1000;
      default:    sel = 4'b0000;
    endcase
  end

  assign bus.m0_grant = m0_grant_c;
  assign bus.m1_grant = m1_grant_c;
  assign bus.s_addr   = addr_mux;
  assign bus.s_din    = din_mux;
  assign bus.s_wr     = wr_mux;
  assign bus.s0_sel   = sel[0];
  assign bus.s1_sel   = sel[1];
  assign bus.s2_sel   = sel[2];
  assign bus.s3_sel   = sel[3];

  // rsel_q is one-hot or zero, so an AND-OR mux gives 0 for the unmapped case.
  assign bus.m_din = ({DATA_W{rsel_q[0]}} & bus.s0_dout)
                   | ({DATA_W{rsel_q[1]}} & bus.s1_dout)
                   | ({DATA_W{rsel_q[2]}} & bus.s2_dout)
                   | ({DATA_W{rsel_q[3]}} & bus.s3_dout);

endmodule

// File: tb/tb_bus_arbiter_mux.sv
module tb_bus_arbiter_mux;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  bus_arbiter_mux_if #(.ADDR_W(8), .DATA_W(32)) bus ();

  bus_arbiter_mux #(.ADDR_W(8), .DATA_W(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic             rst;
    logic             m0_req;
    logic             m0_wr;
    logic [7:0]       m0_addr;
    logic [31:0]      m0_dout;
    logic             m1_req;
    logic             m1_wr;
    logic [7:0]       m1_addr;
    logic [31:0]      m1_dout;
    logic [3:0][31:0] sd;
  } stim_t;

  typedef struct {
    logic        g0;
    logic        g1;
    logic [7:0]  s_addr;
    logic        s_wr;
    logic [31:0] s_din;
    logic [3:0]  sel;
    logic [31:0] m_din;
  } exp_t;

  exp_t  exp_q[$];
  int    n_vec = 0;
  int    n_err = 0;

  // reference model: who owns the bus, and which slave (or -1) was addressed last cycle
  int    owner;
  int    prev_slave;
  stim_t cur;

  // region table for the address map, by top nibble
  function automatic int slave_of(input logic [7:0] a);
    int n;
    n = int'(a >> 4);
    if (n < 1) return 0;
    if (n < 2) return 1;
    if (n < 4) return 2;
    if (n < 6) return 3;
    return -1;
  endfunction

  function automatic stim_t rand_stim();
    stim_t s;
    s.rst     = ($urandom_range(0, 49) == 0);
    s.m0_req  = ($urandom_range(0, 9) < 6);
    s.m0_wr   = 1'($urandom);
    s.m0_addr = 8'($urandom);
    s.m0_dout = $urandom;
    s.m1_req  = ($urandom_range(0, 9) < 6);
    s.m1_wr   = 1'($urandom);
    s.m1_addr = 8'($urandom);
    s.m1_dout = $urandom;
    for (int i = 0; i < 4; i++) s.sd[i] = $urandom;
    return s;
  endfunction

  task automatic drive(input stim_t s);
    reset       = s.rst;
    bus.m0_req  = s.m0_req;
    bus.m0_wr   = s.m0_wr;
    bus.m0_addr = s.m0_addr;
    bus.m0_dout = s.m0_dout;
    bus.m1_req  = s.m1_req;
    bus.m1_wr   = s.m1_wr;
    bus.m1_addr = s.m1_addr;
    bus.m1_dout = s.m1_dout;
    bus.s0_dout = s.sd[0];
    bus.s1_dout = s.sd[1];
    bus.s2_dout = s.sd[2];
    bus.s3_dout = s.sd[3];
  endtask

  // One bus cycle: the edge consumes the previous inputs, then new inputs are applied
  // and the expected outputs for this cycle are queued for the monitor.
  task automatic step(input stim_t s);
    exp_t e;
    int   sl;
    @(posedge clk);
    if (cur.rst) begin
      owner      = 0;
      prev_slave = -1;
    end else begin
      prev_slave = slave_of(owner == 1 ? cur.m1_addr : cur.m0_addr);
      if (owner == 0 && !cur.m0_req && cur.m1_req) owner = 1;
      else if (owner == 1 && !cur.m1_req)          owner = 0;
    end
    #1;
    drive(s);
    cur      = s;
    e.g0     = (owner == 0);
    e.g1     = (owner == 1);
    e.s_addr = (owner == 1) ? s.m1_addr : s.m0_addr;
    e.s_din  = (owner == 1) ? s.m1_dout : s.m0_dout;
    e.s_wr   = (owner == 1) ? (s.m1_wr && s.m1_req) : (s.m0_wr && s.m0_req);
    sl       = slave_of(e.s_addr);
    e.sel    = (sl < 0) ? 4'b0000 : 4'(1 << sl);
    e.m_din  = (prev_slave < 0) ? 32'h0 : s.sd[prev_slave];
    exp_q.push_back(e);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, req);
    end
  endtask

  // monitor: compares every cycle's outputs mid-cycle against the queued expectation
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("m0_grant", 32'(bus.m0_grant), 32'(e.g0));
        chk("m1_grant", 32'(bus.m1_grant), 32'(e.g1));
        chk("s_addr",   32'(bus.s_addr),   32'(e.s_addr));
        chk("s_wr",     32'(bus.s_wr),     32'(e.s_wr));
        chk("s_din",    bus.s_din,         e.s_din);
        chk("sel",      32'({bus.s3_sel, bus.s2_sel, bus.s1_sel, bus.s0_sel}), 32'(e.sel));
        chk("m_din",    bus.m_din,         e.m_din);
      end
    end
  end

  initial begin
    stim_t s;
    s     = rand_stim();
    s.rst = 1'b1;
    drive(s);
    cur   = s;

    // reset held over two edges with random requests
    for (int i = 0; i < 2; i++) begin
      s = rand_stim(); s.rst = 1'b1; step(s);
    end

    // M0 idle, M1 requests at 0x25: handover after one edge, decode to S2
    for (int i = 0; i < 3; i++) begin
      s = rand_stim(); s.rst = 1'b0; s.m0_req = 1'b0; s.m1_req = 1'b1; s.m1_addr = 8'h25;
      step(s);
    end
    // M1 drops, bus returns to M0
    s = rand_stim(); s.rst = 1'b0; s.m0_req = 1'b0; s.m1_req = 1'b0; step(s);

    // both requesting: M0 holds for 10 cycles, then releases to M1
    for (int i = 0; i < 10; i++) begin
      s = rand_stim(); s.rst = 1'b0; s.m0_req = 1'b1; s.m1_req = 1'b1; step(s);
    end
    for (int i = 0; i < 2; i++) begin
      s = rand_stim(); s.rst = 1'b0; s.m0_req = 1'b0; s.m1_req = 1'b1; step(s);
    end
    // M1 owner is not preempted by M0, then releases
    for (int i = 0; i < 4; i++) begin
      s = rand_stim(); s.rst = 1'b0; s.m0_req = 1'b1; s.m1_req = 1'b1; step(s);
    end
    for (int i = 0; i < 2; i++) begin
      s = rand_stim(); s.rst = 1'b0; s.m0_req = 1'b1; s.m1_req = 1'b0; step(s);
    end

    // M0 read of 0x13 returns S1 data next cycle; then unmapped 0x70 write
    s = rand_stim(); s.rst = 1'b0; s.m0_req = 1'b1; s.m1_req = 1'b0; s.m0_wr = 1'b0; s.m0_addr = 8'h13;
    step(s);
    s = rand_stim(); s.rst = 1'b0; s.m0_req = 1'b1; s.m1_req = 1'b0; s.m0_wr = 1'b1; s.m0_addr = 8'h70;
    s.sd[1] = 32'hDEADBEEF;
    step(s);
    s = rand_stim(); s.rst = 1'b0; s.m0_req = 1'b1; s.m1_req = 1'b0; step(s);

    // M1 writing S3 at 0x40, reset pulsed mid-transfer with M0 idle
    s = rand_stim(); s.rst = 1'b0; s.m0_req = 1'b0; s.m1_req = 1'b1; step(s);
    for (int i = 0; i < 2; i++) begin
      s = rand_stim(); s.rst = 1'b0; s.m0_req = 1'b0; s.m1_req = 1'b1; s.m1_wr = 1'b1; s.m1_addr = 8'h40;
      step(s);
    end
    s = rand_stim(); s.rst = 1'b1; s.m0_req = 1'b0; s.m1_req = 1'b1; s.m1_wr = 1'b1; s.m1_addr = 8'h40;
    step(s);
    for (int i = 0; i < 2; i++) begin
      s = rand_stim(); s.rst = 1'b0; s.m0_req = 1'b0; s.m1_req = 1'b1; s.m1_wr = 1'b1; s.m1_addr = 8'h40;
      step(s);
    end

    // random traffic, occasional resets
    for (int i = 0; i < 3000; i++) begin
      s = rand_stim();
      step(s);
    end

    // let the monitor drain; anything still queued was never checked
    repeat (3) @(negedge clk);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
